// File: rtl/eth_frame_arb_pkg.sv
// rtl/eth_frame_arb_pkg.sv - shared types and helpers for the pattern-memory arbiter
//
// Contents:
//   arb_state_t   : arbiter FSM states (IDLE, ACCESS, DONE)
//   grant_width() : width of a requester index for a given requester count
//   TIMEOUT_CNT_MIN_W : minimum width of the optional access timeout counter

package eth_frame_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_CNT_MIN_W = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int grant_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/eth_frame_rr_picker.sv
// rtl/eth_frame_rr_picker.sv - combinational round-robin winner selection
//
// Ports:
//   req    : one request bit per requester
//   last   : index of the previously granted requester
//   winner : first requester with req set, searching from last+1 modulo C_NUM_REQ
//   any    : at least one request bit is set (winner is only meaningful when high)

module eth_frame_rr_picker
    import eth_frame_arb_pkg::*;
#(
    parameter int C_NUM_REQ = 2,
    localparam int GW = grant_width(C_NUM_REQ)
) (
    input  logic [C_NUM_REQ-1:0] req,
    input  logic [GW-1:0]        last,
    output logic [GW-1:0]        winner,
    output logic                 any
);

    // Offset 1 is checked first and offset C_NUM_REQ (= last itself) last, so
    // the previous winner only wins again when nobody else is asking.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = 1; i <= C_NUM_REQ; i++) begin
            logic [GW-1:0] idx;
            idx = GW'((int'(last) + i) % C_NUM_REQ);
            if (!any && req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/eth_frame_pattern_mem_arbiter.sv
// rtl/eth_frame_pattern_mem_arbiter.sv - round-robin sharing of one pattern-memory port
//
// Optional feature macro: ETH_FRAME_ARB_TIMEOUT_EN (abort an access that sees no
// mem_ack within C_TIMEOUT cycles; req_err pulses with req_ack on abort).
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   req_valid   : per-requester request, held until req_ack
//   req_we      : per-requester write enable
//   req_addr    : packed word addresses, requester i at [i*AW +: AW]
//   req_wdata   : packed write data, requester i at [i*DW +: DW]
//   req_ack     : one-cycle completion pulse to the granted requester
//   req_err     : one-cycle abort pulse, coincident with req_ack
//   req_rdata   : read data captured at completion, held until the next one
//   mem_req     : memory request level, high for the whole access
//   mem_we, mem_addr, mem_wdata : access attributes, stable while mem_req is high
//   mem_ack     : one-cycle completion from memory
//   mem_rdata   : memory read data, valid with mem_ack
//   grant_id    : index of the current or most recent granted requester
//   busy        : high whenever the arbiter is not idle

module eth_frame_pattern_mem_arbiter
    import eth_frame_arb_pkg::*;
#(
    parameter int C_NUM_REQ    = 2,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_WIDTH = 11,
    parameter int C_TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [C_NUM_REQ-1:0]              req_valid,
    input  logic [C_NUM_REQ-1:0]              req_we,
    input  logic [C_NUM_REQ*C_ADDR_WIDTH-1:0] req_addr,
    input  logic [C_NUM_REQ*C_DATA_WIDTH-1:0] req_wdata,
    output logic [C_NUM_REQ-1:0]              req_ack,
    output logic [C_NUM_REQ-1:0]              req_err,
    output logic [C_DATA_WIDTH-1:0]           req_rdata,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [C_ADDR_WIDTH-1:0]           mem_addr,
    output logic [C_DATA_WIDTH-1:0]           mem_wdata,
    input  logic                              mem_ack,
    input  logic [C_DATA_WIDTH-1:0]           mem_rdata,
    output logic [grant_width(C_NUM_REQ)-1:0] grant_id,
    output logic                              busy
);

    localparam int GW = grant_width(C_NUM_REQ);

    if (C_NUM_REQ < 2 || C_NUM_REQ > 8 || C_TIMEOUT < 1) begin : g_param_check
        $error("eth_frame_pattern_mem_arbiter: C_NUM_REQ must be 2..8 and C_TIMEOUT >= 1");
    end

    arb_state_t    state;
    logic [GW-1:0] last;
    logic [GW-1:0] winner;
    logic          any;

    eth_frame_rr_picker #(
        .C_NUM_REQ (C_NUM_REQ)
    ) u_picker (
        .req    (req_valid),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    assign busy = (state != IDLE);

`ifdef ETH_FRAME_ARB_TIMEOUT_EN
    localparam int TW = ($clog2(C_TIMEOUT + 1) > TIMEOUT_CNT_MIN_W) ?
                        $clog2(C_TIMEOUT + 1) : TIMEOUT_CNT_MIN_W;
    // Counts ACCESS cycles already spent; the abort fires in the C_TIMEOUT-th one.
    logic [TW-1:0] timeout_cnt;
`else
    assign req_err = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= GW'(C_NUM_REQ - 1);
            grant_id  <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ack   <= '0;
            req_rdata <= '0;
`ifdef ETH_FRAME_ARB_TIMEOUT_EN
            req_err     <= '0;
            timeout_cnt <= '0;
`endif
        end else begin
            req_ack <= '0;
`ifdef ETH_FRAME_ARB_TIMEOUT_EN
            req_err <= '0;
`endif
            unique case (state)
                IDLE: begin
                    // A stray mem_ack here has no transaction to complete and is dropped.
                    if (any) begin
                        mem_we    <= req_we[winner];
                        mem_addr  <= req_addr[int'(winner)*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                        mem_wdata <= req_wdata[int'(winner)*C_DATA_WIDTH +: C_DATA_WIDTH];
                        mem_req   <= 1'b1;
                        grant_id  <= winner;
                        last      <= winner;
                        state     <= ACCESS;
`ifdef ETH_FRAME_ARB_TIMEOUT_EN
                        timeout_cnt <= '0;
`endif
                    end
                end
                ACCESS: begin
                    // The ack is delivered even if the requester has since dropped req_valid.
                    if (mem_ack) begin
                        mem_req           <= 1'b0;
                        req_rdata         <= mem_rdata;
                        req_ack[grant_id] <= 1'b1;
                        state             <= DONE;
                    end
`ifdef ETH_FRAME_ARB_TIMEOUT_EN
                    else if (timeout_cnt == TW'(C_TIMEOUT - 1)) begin
                        mem_req           <= 1'b0;
                        req_rdata         <= '0;
                        req_ack[grant_id] <= 1'b1;
                        req_err[grant_id] <= 1'b1;
                        state             <= DONE;
                    end else begin
                        timeout_cnt <= timeout_cnt + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // Idle gap: mem_req stays low and the requester can drop req_valid.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_pattern_mem_arbiter.sv
// tb/tb_eth_frame_pattern_mem_arbiter.sv - scoreboard bench for the pattern-memory arbiter

module tb_eth_frame_pattern_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_we, req_ack, req_err;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   req_rdata;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic [0:0]      grant_id;
    logic            busy;

    logic          v_valid [N];
    logic          v_we    [N];
    logic [AW-1:0] v_addr  [N];
    logic [DW-1:0] v_wd    [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_valid[g]            = v_valid[g];
        assign req_we[g]               = v_we[g];
        assign req_addr[g*AW +: AW]    = v_addr[g];
        assign req_wdata[g*DW +: DW]   = v_wd[g];
    end

    eth_frame_pattern_mem_arbiter #(
        .C_NUM_REQ(N), .C_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW), .C_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ack(req_ack), .req_err(req_err), .req_rdata(req_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rd;
        bit            err;
    } exp_t;

    exp_t exp_q [N][$];
    logic [DW-1:0] mem_arr [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA500_0000 ^ (a * 32'h0001_0003);
    endfunction

    // Round-robin rule: first pending requester after the previous winner.
    function automatic int rr_pick(input int prev, input logic [N-1:0] v);
        for (int i = 1; i <= N; i++)
            if (v[(prev + i) % N]) return (prev + i) % N;
        return -1;
    endfunction

    // Memory model: acks after cur_lat cycles of mem_req, optional hold / stray ack.
    bit            mem_hold = 1'b0;
    bit            stray    = 1'b0;
    int            lat_max  = 1;
    int            cur_lat  = 1;
    int            mcnt     = 0;
    logic [DW-1:0] drv_rdata = '0;

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
            mcnt    = 0;
        end else if (stray) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5A5A_5A5A;
            stray     = 1'b0;
        end else if (mem_req && !mem_hold) begin
            mcnt++;
            if (mcnt >= cur_lat) begin
                mem_ack = 1'b1;
                mcnt    = 0;
                if (mem_we) begin
                    mem_arr[mem_addr] = mem_wdata;
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = mem_arr[mem_addr];
                end
                drv_rdata = mem_rdata;
                cur_lat   = $urandom_range(1, lat_max);
            end
        end else if (!mem_req) begin
            mcnt = 0;
        end
    end

    // Monitor / scoreboard
    int            last_b, cur_k, cyc = 0, last_ack_cyc = -100, last_gap = 0;
    logic          prev_req;
    logic [DW-1:0] hold_exp;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd;
    int            grant_log [$];

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            last_b       = N - 1;
            cur_k        = -1;
            prev_req     = 1'b0;
            hold_exp     = '0;
            last_ack_cyc = -100;
            for (int k = 0; k < N; k++) exp_q[k].delete();
        end else begin
            logic [N-1:0] exp_ack;
            exp_t e;
            int pred;
            if (cyc == last_ack_cyc + 1) check(mem_req == 1'b0, "mem_req_gap", mem_req, 0);
            if (mem_req && !prev_req) begin
                pred = rr_pick(last_b, req_valid);
                check(pred >= 0, "grant_without_request", req_valid, 1);
                check(int'(grant_id) == pred, "grant_id", grant_id, pred);
                cur_k = pred;
                if (pred >= 0) begin
                    last_b = pred;
                    if (exp_q[pred].size() == 0) begin
                        check(1'b0, "no_expected_txn", pred, 0);
                    end else begin
                        e = exp_q[pred][0];
                        check(mem_we == e.we, "mem_we", mem_we, e.we);
                        check(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
                        if (e.we) check(mem_wdata == e.wd, "mem_wdata", mem_wdata, e.wd);
                    end
                end
                cur_we   = mem_we;
                cur_addr = mem_addr;
                cur_wd   = mem_wdata;
                last_gap = cyc - last_ack_cyc;
                grant_log.push_back(pred);
            end else if (mem_req) begin
                check(mem_we == cur_we && mem_addr == cur_addr && mem_wdata == cur_wd,
                      "mem_stable", {mem_we, mem_addr}, {cur_we, cur_addr});
            end
            if (mem_req) check(busy == 1'b1, "busy_in_access", busy, 1);
            if (req_ack != '0) begin
                exp_ack = (cur_k < 0) ? '0 : N'(1 << cur_k);
                check(req_ack == exp_ack, "req_ack_onehot", req_ack, exp_ack);
                check(mem_req == 1'b0, "mem_req_low_at_ack", mem_req, 0);
                hold_exp = drv_rdata;
                if (cur_k >= 0 && exp_q[cur_k].size() > 0) begin
                    e = exp_q[cur_k].pop_front();
                    if (!e.we) check(req_rdata == e.rd, "req_rdata", req_rdata, e.rd);
                    check(req_err == (e.err ? exp_ack : '0), "req_err", req_err, e.err ? exp_ack : '0);
                    if (e.err) hold_exp = '0;
                end else begin
                    check(1'b0, "ack_without_txn", req_ack, 0);
                end
                last_ack_cyc = cyc;
            end else begin
                check(req_err == '0, "req_err_idle", req_err, 0);
                check(req_rdata == hold_exp, "req_rdata_hold", req_rdata, hold_exp);
            end
            prev_req = mem_req;
        end
    end

    task automatic issue(input int k, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit err, input bit keep, output int lat);
        exp_t e;
        @(negedge clk);
        v_valid[k] = 1'b1;
        v_we[k]    = we;
        v_addr[k]  = a;
        v_wd[k]    = wd;
        e.we = we; e.addr = a; e.wd = wd; e.err = err;
        e.rd = (we || err) ? '0 : ref_mem[a];
        if (we && !err) ref_mem[a] = wd;
        exp_q[k].push_back(e);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!req_ack[k] && lat < 300);
        if (!req_ack[k]) check(1'b0, "ack_wait_expired", lat, 0);
        if (!keep) begin
            @(negedge clk);
            v_valid[k] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int l, base, bad;
        exp_t e;
        for (int i = 0; i < 2**AW; i++) begin
            mem_arr[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        mem_arr[11'h123] = 32'hDEADBEEF;
        ref_mem[11'h123] = 32'hDEADBEEF;
        for (int k = 0; k < N; k++) begin
            v_valid[k] = 1'b0; v_we[k] = 1'b0; v_addr[k] = '0; v_wd[k] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check({mem_req, mem_we, busy, req_ack, req_err} == '0, "reset_ctrl", {mem_req, mem_we, busy, req_ack, req_err}, 0);
        check({mem_addr, mem_wdata, req_rdata, grant_id} == '0, "reset_data", {mem_addr, grant_id}, 0);

        // Contention: both requesters re-request immediately, grants must alternate from 0.
        base = grant_log.size();
        fork
            begin issue(0, 1, 11'h010, 32'h1111_0000, 0, 0, l); issue(0, 1, 11'h012, 32'h1111_0001, 0, 0, l); end
            begin issue(1, 1, 11'h011, 32'h2222_0000, 0, 0, l); issue(1, 1, 11'h013, 32'h2222_0001, 0, 0, l); end
        join
        for (int i = 0; i < 4; i++)
            check(grant_log.size() > base + i && grant_log[base + i] == i % 2, "contention_order",
                  (grant_log.size() > base + i) ? grant_log[base + i] : -1, i % 2);

        // Single read with a one-cycle memory.
        repeat (2) @(negedge clk);
        issue(0, 0, 11'h123, '0, 0, 0, l);
        check(l == 2, "valid_to_ack_edges", l, 2);
        check(req_rdata == 32'hDEADBEEF, "single_read_data", req_rdata, 32'hDEADBEEF);

        // Back-to-back from requester 1, valid kept through the ack.
        repeat (2) @(negedge clk);
        issue(1, 0, 11'h101, '0, 0, 1, l);
        issue(1, 0, 11'h7FF, '0, 0, 0, l);
        check(last_gap == 2, "back_to_back_gap", last_gap, 2);
        check(req_rdata == init_word(11'h7FF), "back_to_back_data", req_rdata, init_word(11'h7FF));

        // Reset during ACCESS followed by a stray ack.
        repeat (2) @(negedge clk);
        mem_hold = 1'b1;
        @(negedge clk);
        v_valid[1] = 1'b1; v_we[1] = 1'b0; v_addr[1] = 11'h055;
        e.we = 0; e.addr = 11'h055; e.wd = '0; e.err = 0; e.rd = ref_mem[11'h055];
        exp_q[1].push_back(e);
        bad = 0;
        while (!mem_req && bad < 20) begin @(posedge clk); #1; bad++; end
        check(mem_req == 1'b1, "reset_test_access", mem_req, 1);
        @(negedge clk);
        rst = 1'b1;
        v_valid[1] = 1'b0;
        @(posedge clk); #2;
        stray = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check({mem_req, busy, req_ack, req_err, grant_id} == '0, "after_reset_ctrl", {mem_req, busy, req_ack, grant_id}, 0);
        check({mem_addr, mem_we, req_rdata} == '0, "after_reset_data", mem_addr, 0);
        base = grant_log.size();
        fork
            issue(0, 1, 11'h020, 32'h3333_0000, 0, 0, l);
            issue(1, 1, 11'h021, 32'h4444_0000, 0, 0, l);
        join
        check(grant_log.size() > base && grant_log[base] == 0, "first_grant_after_reset",
              (grant_log.size() > base) ? grant_log[base] : -1, 0);

        // Randomised traffic, each requester confined to its own address residue.
        lat_max = 3;
        for (int k = 0; k < N; k++) begin
            fork
                automatic int kk = k;
                begin
                    int lt;
                    bit w, kp;
                    logic [AW-1:0] a;
                    kp = 1'b0;
                    for (int t = 0; t < 12; t++) begin
                        if (!kp) repeat ($urandom_range(0, 3)) @(negedge clk);
                        w  = 1'($urandom_range(0, 1));
                        kp = (t < 11) && ($urandom_range(0, 1) == 1);
                        a  = AW'($urandom_range(0, (2**AW) / N - 1) * N + kk);
                        issue(kk, w, a, $urandom, 0, kp, lt);
                    end
                end
            join_none
        end
        wait fork;
        lat_max = 1;
        repeat (3) @(negedge clk);

`ifdef ETH_FRAME_ARB_TIMEOUT_EN
        mem_hold = 1'b1;
        issue(0, 0, 11'h030, '0, 1, 0, l);
        check(l == TO + 1, "timeout_edges", l, TO + 1);
        check(req_rdata == '0, "timeout_rdata", req_rdata, 0);
        mem_hold = 1'b0;
`else
        mem_hold = 1'b1;
        @(negedge clk);
        v_valid[0] = 1'b1; v_we[0] = 1'b0; v_addr[0] = 11'h030;
        e.we = 0; e.addr = 11'h030; e.wd = '0; e.err = 0; e.rd = ref_mem[11'h030];
        exp_q[0].push_back(e);
        bad = 0;
        repeat (1000) begin
            @(posedge clk); #1;
            if (!busy || req_ack != '0) bad++;
        end
        check(bad == 0, "busy_held_without_ack", bad, 0);
        @(negedge clk);
        rst = 1'b1;
        v_valid[0] = 1'b0;
        mem_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
`endif
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
